// File: rtl/bram_pl_bist_seq.sv
// Preload-bus BIST sequencer for the 18K BRAM array.
// Drives the daisy-chained preload bus through four test phases:
// clear tile status, broadcast checkerboard write, broadcast read with
// in-tile compare, then targeted read-back of every tile's sticky
// mismatch word. The first failing tile in row-major scan order is
// reported on fail_*; pass_o drops if any tile reports a mismatch.

// Bus-protocol properties for the sequencer, kept apart from the datapath.
module bram_pl_bist_seq_chk (
    input logic PL_CLK_i,
    input logic RESET_ni,
    input logic pl_ena_s,
    input logic pl_wen_s,
    input logic pl_ren_s,
    input logic pl_init_s,
    input logic busy_s,
    input logic done_s
);

    // A tile can never be asked to write and read in the same cycle.
    wen_ren_excl_a : assert property (@(posedge PL_CLK_i) disable iff (!RESET_ni)
        !(pl_wen_s && pl_ren_s));

    // Any strobe on the bus must be qualified by ENA.
    strobe_needs_ena_a : assert property (@(posedge PL_CLK_i) disable iff (!RESET_ni)
        (pl_wen_s || pl_ren_s || pl_init_s) |-> pl_ena_s);

    // Completion is reported only once the sequence has released busy.
    done_not_busy_a : assert property (@(posedge PL_CLK_i) disable iff (!RESET_ni)
        done_s |-> !busy_s);

    // Completion is a single-cycle pulse.
    done_pulse_a : assert property (@(posedge PL_CLK_i) disable iff (!RESET_ni)
        done_s |=> !done_s);

endmodule

module bram_pl_bist_seq #(
    parameter int NUM_ROW = 4,
    parameter int NUM_COL = 4
) (
    input  logic        PL_CLK_i,
    input  logic        RESET_ni,
    input  logic        start_i,
    input  logic [17:0] pattern_i,
    input  logic [9:0]  last_addr_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [9:0]  fail_row_o,
    output logic [9:0]  fail_col_o,
    output logic [17:0] fail_status_o,
    output logic        PL_ENA_o,
    output logic        PL_WEN_o,
    output logic        PL_REN_o,
    output logic        PL_INIT_o,
    output logic [31:0] PL_ADDR_o,
    output logic [17:0] PL_DATA_o,
    input  logic [17:0] PL_DATA_IN_i
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_WRITE  = 3'd2,
        ST_READ   = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_STATUS = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    localparam logic [9:0] LAST_ROW = 10'(NUM_ROW);
    localparam logic [9:0] LAST_COL = 10'(NUM_COL);

    // Checkerboard background: odd word addresses carry the inverted pattern.
    function automatic logic [17:0] checker_word(input logic [9:0] addr, input logic [17:0] pattern);
        return addr[0] ? ~pattern : pattern;
    endfunction

    // Targeted tile access: row/col IDs in the upper fields, word 0.
    function automatic logic [31:0] tile_addr(input logic [9:0] row, input logic [9:0] col);
        return {row, col, 12'h000};
    endfunction

    // Broadcast access: row/col wildcard (0), word address in the low field.
    function automatic logic [31:0] bcast_addr(input logic [9:0] addr);
        return {22'h000000, addr};
    endfunction

    state_t      state_r;
    logic [9:0]  row_r;
    logic [9:0]  col_r;
    logic [9:0]  addr_r;
    logic [17:0] pattern_r;
    logic [9:0]  last_addr_r;
    logic        status_sample_r;

    logic [9:0]  row_nxt_s;
    logic [9:0]  col_nxt_s;
    logic        last_tile_s;
    logic        last_word_s;

    // Row-major tile scan: column runs fastest and wraps back to 1.
    always_comb begin
        row_nxt_s = row_r;
        col_nxt_s = col_r;
        if (col_r == LAST_COL) begin
            col_nxt_s = 10'd1;
            row_nxt_s = row_r + 10'd1;
        end else begin
            col_nxt_s = col_r + 10'd1;
            row_nxt_s = row_r;
        end
    end

    assign last_tile_s = (row_r == LAST_ROW) && (col_r == LAST_COL);
    assign last_word_s = (addr_r == last_addr_r);

    // Sequencer FSM with registered bus and result outputs.
    always_ff @(posedge PL_CLK_i or negedge RESET_ni) begin
        if (!RESET_ni) begin
            state_r         <= ST_IDLE;
            row_r           <= 10'd0;
            col_r           <= 10'd0;
            addr_r          <= 10'd0;
            pattern_r       <= 18'h00000;
            last_addr_r     <= 10'd0;
            status_sample_r <= 1'b0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            pass_o          <= 1'b0;
            fail_row_o      <= 10'd0;
            fail_col_o      <= 10'd0;
            fail_status_o   <= 18'h00000;
            PL_ENA_o        <= 1'b0;
            PL_WEN_o        <= 1'b0;
            PL_REN_o        <= 1'b0;
            PL_INIT_o       <= 1'b0;
            PL_ADDR_o       <= 32'h00000000;
            PL_DATA_o       <= 18'h00000;
        end else begin
            done_o <= 1'b0;

            // The status word of the tile addressed last cycle is on the
            // chain tail now; the tile ID is still held on PL_ADDR_o.
            if (status_sample_r) begin
                if (PL_DATA_IN_i != 18'h00000) begin
                    pass_o <= 1'b0;
                    if (pass_o) begin
                        fail_row_o    <= PL_ADDR_o[31:22];
                        fail_col_o    <= PL_ADDR_o[21:12];
                        fail_status_o <= PL_DATA_IN_i;
                    end
                end
            end

            case (state_r)
                ST_IDLE: begin
                    PL_ENA_o        <= 1'b0;
                    PL_WEN_o        <= 1'b0;
                    PL_REN_o        <= 1'b0;
                    PL_INIT_o       <= 1'b0;
                    PL_ADDR_o       <= 32'h00000000;
                    PL_DATA_o       <= 18'h00000;
                    status_sample_r <= 1'b0;
                    if (start_i) begin
                        pattern_r     <= pattern_i;
                        last_addr_r   <= last_addr_i;
                        busy_o        <= 1'b1;
                        pass_o        <= 1'b1;
                        fail_row_o    <= 10'd0;
                        fail_col_o    <= 10'd0;
                        fail_status_o <= 18'h00000;
                        row_r         <= 10'd1;
                        col_r         <= 10'd1;
                        addr_r        <= 10'd0;
                        state_r       <= ST_CLEAR;
                    end
                end

                ST_CLEAR: begin
                    PL_ENA_o  <= 1'b1;
                    PL_WEN_o  <= 1'b1;
                    PL_REN_o  <= 1'b0;
                    PL_INIT_o <= 1'b0;
                    PL_ADDR_o <= tile_addr(row_r, col_r);
                    PL_DATA_o <= 18'h00000;
                    if (last_tile_s) begin
                        addr_r  <= 10'd0;
                        state_r <= ST_WRITE;
                    end else begin
                        row_r <= row_nxt_s;
                        col_r <= col_nxt_s;
                    end
                end

                ST_WRITE: begin
                    PL_ENA_o  <= 1'b1;
                    PL_WEN_o  <= 1'b1;
                    PL_REN_o  <= 1'b0;
                    PL_INIT_o <= 1'b0;
                    PL_ADDR_o <= bcast_addr(addr_r);
                    PL_DATA_o <= checker_word(addr_r, pattern_r);
                    if (last_word_s) begin
                        addr_r  <= 10'd0;
                        state_r <= ST_READ;
                    end else begin
                        addr_r <= addr_r + 10'd1;
                    end
                end

                ST_READ: begin
                    PL_ENA_o  <= 1'b1;
                    PL_WEN_o  <= 1'b0;
                    PL_REN_o  <= 1'b1;
                    PL_INIT_o <= 1'b1;
                    PL_ADDR_o <= bcast_addr(addr_r);
                    PL_DATA_o <= checker_word(addr_r, pattern_r);
                    if (last_word_s) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        addr_r <= addr_r + 10'd1;
                    end
                end

                ST_DRAIN: begin
                    // Address and expected data stay put so the tiles'
                    // delayed compare of the last word sees a stable bus.
                    PL_ENA_o  <= 1'b1;
                    PL_WEN_o  <= 1'b0;
                    PL_REN_o  <= 1'b0;
                    PL_INIT_o <= 1'b1;
                    row_r     <= 10'd1;
                    col_r     <= 10'd1;
                    state_r   <= ST_STATUS;
                end

                ST_STATUS: begin
                    PL_ENA_o        <= 1'b1;
                    PL_WEN_o        <= 1'b0;
                    PL_REN_o        <= 1'b1;
                    PL_INIT_o       <= 1'b1;
                    PL_ADDR_o       <= tile_addr(row_r, col_r);
                    PL_DATA_o       <= 18'h00000;
                    status_sample_r <= 1'b1;
                    if (last_tile_s) begin
                        state_r <= ST_DONE;
                    end else begin
                        row_r <= row_nxt_s;
                        col_r <= col_nxt_s;
                    end
                end

                ST_DONE: begin
                    PL_ENA_o        <= 1'b0;
                    PL_WEN_o        <= 1'b0;
                    PL_REN_o        <= 1'b0;
                    PL_INIT_o       <= 1'b0;
                    PL_ADDR_o       <= 32'h00000000;
                    PL_DATA_o       <= 18'h00000;
                    status_sample_r <= 1'b0;
                    done_o          <= 1'b1;
                    busy_o          <= 1'b0;
                    state_r         <= ST_IDLE;
                end

                default: begin
                    PL_ENA_o        <= 1'b0;
                    PL_WEN_o        <= 1'b0;
                    PL_REN_o        <= 1'b0;
                    PL_INIT_o       <= 1'b0;
                    PL_ADDR_o       <= 32'h00000000;
                    PL_DATA_o       <= 18'h00000;
                    status_sample_r <= 1'b0;
                    busy_o          <= 1'b0;
                    state_r         <= ST_IDLE;
                end
            endcase
        end
    end

    bram_pl_bist_seq_chk u_chk (
        .PL_CLK_i  (PL_CLK_i),
        .RESET_ni  (RESET_ni),
        .pl_ena_s  (PL_ENA_o),
        .pl_wen_s  (PL_WEN_o),
        .pl_ren_s  (PL_REN_o),
        .pl_init_s (PL_INIT_o),
        .busy_s    (busy_o),
        .done_s    (done_o)
    );

endmodule
